// File: rtl/pucch1_spread_ctrl_if.sv
// Spreader and symbol-stream signals of the PUCCH format 1 spreading controller.
// The controller connects through the master modport; the spreader/consumer side
// connects through the slave modport.
interface pucch1_spread_ctrl_if;
  // spreader request/response
  logic       o_sp_start;
  logic       o_sp_next;
  logic [2:0] o_sp_nSF;
  logic [2:0] o_sp_occi;
  logic [4:0] i_sp_wi_phi;
  logic       i_sp_valid;
  logic       i_sp_is_supported;
  // data-symbol cover-phase stream
  logic       o_sym_valid;
  logic       i_sym_ready;
  logic [4:0] o_sym_phi;
  logic       o_sym_hop;
  logic [2:0] o_sym_idx;

  modport master (
    output o_sp_start, o_sp_next, o_sp_nSF, o_sp_occi,
    input  i_sp_wi_phi, i_sp_valid, i_sp_is_supported,
    output o_sym_valid, o_sym_phi, o_sym_hop, o_sym_idx,
    input  i_sym_ready
  );

  modport slave (
    input  o_sp_start, o_sp_next, o_sp_nSF, o_sp_occi,
    output i_sp_wi_phi, i_sp_valid, i_sp_is_supported,
    input  o_sym_valid, o_sym_phi, o_sym_hop, o_sym_idx,
    output i_sym_ready
  );
endinterface

// File: rtl/pucch1_spread_ctrl.sv
// PUCCH format 1 data-field sequencer: validates the configuration, drives the
// orthogonal-cover spreader one element at a time per hop and presents each
// returned cover phase on a valid/ready symbol stream.
module pucch1_spread_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic [3:0]                  i_nsymb,
  input  logic                        i_hop,
  input  logic [2:0]                  i_occi,
  pucch1_spread_ctrl_if.master        sp_if,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [1:0]                  o_err
);

  // Wait counter runs 0..TIMEOUT-1; the last value ends the wait.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_START = 3'd2,
    S_REQ   = 3'd3,
    S_WAIT  = 3'd4,
    S_OUT   = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t          r_state;
  logic [3:0]      r_nsymb;
  logic            r_hop_en;
  logic [2:0]      r_occi;
  logic            r_hop_idx;
  logic [2:0]      r_m;
  logic [CW-1:0]   r_cnt;
  logic            r_sp_start;
  logic            r_sp_next;
  logic [2:0]      r_sp_nsf;
  logic [2:0]      r_sp_occi;
  logic            r_sym_valid;
  logic [4:0]      r_sym_phi;
  logic            r_done;
  logic [1:0]      r_err;

  logic [2:0]      w_half;
  logic [2:0]      w_quarter;
  logic [2:0]      w_nsf0;
  logic [2:0]      w_nsf1;
  logic [2:0]      w_nsf_cur;
  logic            w_cfg_bad;
  logic            w_last_m;

  // Per-hop spreading factors. With hopping, hop 1 is never shorter than hop 0,
  // so hop 0 alone bounds the legal cover index in both modes.
  assign w_half    = r_nsymb[3:1];
  assign w_quarter = {1'b0, r_nsymb[3:2]};
  assign w_nsf0    = r_hop_en ? w_quarter : w_half;
  assign w_nsf1    = w_half - w_quarter;
  assign w_nsf_cur = r_hop_idx ? w_nsf1 : w_nsf0;
  assign w_cfg_bad = (r_nsymb < 4'd4) || (r_nsymb > 4'd14) || (r_occi >= w_nsf0);
  assign w_last_m  = ({1'b0, r_m} + 4'd1) >= {1'b0, w_nsf_cur};

  // Sequencer state, latched configuration and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_nsymb     <= '0;
      r_hop_en    <= 1'b0;
      r_occi      <= '0;
      r_hop_idx   <= 1'b0;
      r_m         <= '0;
      r_cnt       <= '0;
      r_sp_start  <= 1'b0;
      r_sp_next   <= 1'b0;
      r_sp_nsf    <= '0;
      r_sp_occi   <= '0;
      r_sym_valid <= 1'b0;
      r_sym_phi   <= '0;
      r_done      <= 1'b0;
      r_err       <= '0;
    end else begin
      // pulses default low; each is raised only on entry to its state
      r_sp_start <= 1'b0;
      r_sp_next  <= 1'b0;
      r_done     <= 1'b0;
      if (i_abort) begin
        r_state     <= S_IDLE;
        r_sym_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_nsymb   <= i_nsymb;
              r_hop_en  <= i_hop;
              r_occi    <= i_occi;
              r_hop_idx <= 1'b0;
              r_m       <= '0;
              r_err     <= 2'd0;
              r_state   <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (w_cfg_bad) begin
              r_err   <= 2'd1;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_sp_start <= 1'b1;
              r_sp_nsf   <= w_nsf0;
              r_sp_occi  <= r_occi;
              r_state    <= S_START;
            end
          end
          S_START: begin
            r_sp_next <= 1'b1;
            r_state   <= S_REQ;
          end
          S_REQ: begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (sp_if.i_sp_valid) begin
              if (!sp_if.i_sp_is_supported) begin
                r_err   <= 2'd2;
                r_done  <= 1'b1;
                r_state <= S_FIN;
              end else begin
                r_sym_phi   <= sp_if.i_sp_wi_phi;
                r_sym_valid <= 1'b1;
                r_state     <= S_OUT;
              end
            end else if (r_cnt == TO_LAST) begin
              r_err   <= 2'd3;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_OUT: begin
            if (sp_if.i_sym_ready) begin
              r_sym_valid <= 1'b0;
              if (!w_last_m) begin
                r_m       <= r_m + 3'd1;
                r_sp_next <= 1'b1;
                r_state   <= S_REQ;
              end else if (!r_hop_idx && r_hop_en) begin
                r_hop_idx  <= 1'b1;
                r_m        <= '0;
                r_sp_start <= 1'b1;
                r_sp_nsf   <= w_nsf1;
                r_sp_occi  <= r_occi;
                r_state    <= S_START;
              end else begin
                r_err   <= 2'd0;
                r_done  <= 1'b1;
                r_state <= S_FIN;
              end
            end
          end
          S_FIN: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign sp_if.o_sp_start  = r_sp_start;
  assign sp_if.o_sp_next   = r_sp_next;
  assign sp_if.o_sp_nSF    = r_sp_nsf;
  assign sp_if.o_sp_occi   = r_sp_occi;
  assign sp_if.o_sym_valid = r_sym_valid;
  assign sp_if.o_sym_phi   = r_sym_phi;
  assign sp_if.o_sym_hop   = r_hop_idx;
  assign sp_if.o_sym_idx   = r_m;
  assign o_busy            = (r_state != S_IDLE);
  assign o_done            = r_done;
  assign o_err             = r_err;

endmodule

// File: tb/tb_pucch1_spread_ctrl.sv
// Directed bench for pucch1_spread_ctrl: reactive spreader model, event monitor
// and a linear sequence of directed steps with immediate-assertion checks.
module tb_pucch1_spread_ctrl;

  localparam int TIMEOUT = 15;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic       i_abort;
  logic [3:0] i_nsymb;
  logic       i_hop;
  logic [2:0] i_occi;
  logic       o_busy;
  logic       o_done;
  logic [1:0] o_err;

  pucch1_spread_ctrl_if bus ();

  pucch1_spread_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_abort (i_abort),
    .i_nsymb (i_nsymb),
    .i_hop   (i_hop),
    .i_occi  (i_occi),
    .sp_if   (bus),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // spreader model control: 0 normal, 1 unsupported, 2 silent
  int sp_mode = 0;

  // monitor records
  logic [5:0] q_start[$];
  logic [8:0] q_sym[$];
  int n_next = 0;
  int n_done = 0;
  int n_valid_cyc = 0;
  int n_overlap = 0;

  int t_next;
  int t_done;

  function automatic logic [4:0] model_phi(input int nsf, input int occi, input int m);
    return 5'((nsf + 5 * occi + 3 * m) % 24);
  endfunction

  function automatic logic [31:0] outs_vec();
    return {10'd0, o_busy, o_done, o_err, bus.o_sp_start, bus.o_sp_next, bus.o_sp_nSF,
            bus.o_sp_occi, bus.o_sym_valid, bus.o_sym_phi, bus.o_sym_hop, bus.o_sym_idx};
  endfunction

  // Spreader model: answers each o_sp_next one cycle later (while the DUT waits).
  int  m_nsf = 0;
  int  m_occi = 0;
  int  m_k = 0;
  bit  m_pend = 0;
  always @(negedge clk) begin
    bus.i_sp_valid        = 1'b0;
    bus.i_sp_is_supported = 1'b0;
    bus.i_sp_wi_phi       = 5'd0;
    if (!rst_n) begin
      m_pend = 0;
    end else begin
      if (m_pend) begin
        m_pend = 0;
        if (sp_mode != 2) begin
          bus.i_sp_valid        = 1'b1;
          bus.i_sp_is_supported = (sp_mode == 0);
          bus.i_sp_wi_phi       = model_phi(m_nsf, m_occi, m_k);
          m_k++;
        end
      end
      if (bus.o_sp_start) begin
        m_nsf  = int'(bus.o_sp_nSF);
        m_occi = int'(bus.o_sp_occi);
        m_k    = 0;
      end
      if (bus.o_sp_next) m_pend = 1;
    end
  end

  // Monitor: logs spreader starts, symbol transfers and pulse counts.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_sp_start) q_start.push_back({bus.o_sp_nSF, bus.o_sp_occi});
      if (bus.o_sp_next) n_next++;
      if (o_done) n_done++;
      if (bus.o_sym_valid) n_valid_cyc++;
      if (bus.o_sym_valid && bus.i_sym_ready)
        q_sym.push_back({bus.o_sym_hop, bus.o_sym_idx, bus.o_sym_phi});
      if (int'(bus.o_sp_start) + int'(bus.o_sp_next) + int'(o_done) > 1) n_overlap++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic start_seq(input logic [3:0] n, input logic h, input logic [2:0] oc);
    i_nsymb = n;
    i_hop   = h;
    i_occi  = oc;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    t_next = -1;
    while (!o_done && n < bound) begin
      if (bus.o_sp_next && t_next < 0) t_next = n;
      tick();
      n++;
    end
    t_done = n;
    check("done_seen", {31'd0, o_done}, 32'd1);
  endtask

  task automatic wait_sym(input int bound);
    int n;
    n = 0;
    while (!bus.o_sym_valid && n < bound) begin
      tick();
      n++;
    end
    check("sym_valid_seen", {31'd0, bus.o_sym_valid}, 32'd1);
  endtask

  task automatic check_hop(input string tag, input int base, input logic h, input int nsf,
                           input int occi);
    logic [8:0] e;
    for (int i = 0; i < nsf; i++) begin
      if (base + i < q_sym.size()) e = q_sym[base + i];
      else e = 'x;
      check($sformatf("%s_sym%0d", tag, i), {23'd0, e}, {23'd0, h, 3'(i), model_phi(nsf, occi, i)});
    end
  endtask

  task automatic cfg_err(input string tag, input logic [3:0] n, input logic h,
                         input logic [2:0] oc);
    int nn;
    int ns;
    nn = n_next;
    ns = q_start.size();
    start_seq(n, h, oc);
    check({tag, "_no_early_done"}, {31'd0, o_done}, 32'd0);
    tick();
    check({tag, "_done"}, {31'd0, o_done}, 32'd1);
    check({tag, "_err"}, {30'd0, o_err}, 32'd1);
    tick();
    check({tag, "_err_hold"}, {30'd0, o_err}, 32'd1);
    check({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_no_next"}, n_next - nn, 32'd0);
    check({tag, "_no_start"}, q_start.size() - ns, 32'd0);
  endtask

  initial begin
    int bs;
    int bst;
    int vc;
    int nn;
    int nd;
    logic [31:0] snap;

    rst_n = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_nsymb = '0;
    i_hop = 1'b0;
    i_occi = '0;
    bus.i_sym_ready = 1'b0;
    tick();
    tick();
    check("reset_outs", outs_vec(), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", {31'd0, o_busy}, 32'd0);

    // N=14 no hop occi=3, consumer always ready
    bus.i_sym_ready = 1'b1;
    sp_mode = 0;
    bs = q_sym.size();
    bst = q_start.size();
    vc = n_valid_cyc;
    start_seq(4'd14, 1'b0, 3'd3);
    check("t1_busy", {31'd0, o_busy}, 32'd1);
    check("t1_no_start_yet", {31'd0, bus.o_sp_start}, 32'd0);
    tick();
    check("t1_start_latency", {31'd0, bus.o_sp_start}, 32'd1);
    check("t1_nsf", {29'd0, bus.o_sp_nSF}, 32'd7);
    check("t1_occi", {29'd0, bus.o_sp_occi}, 32'd3);
    wait_done(200);
    check("t1_err", {30'd0, o_err}, 32'd0);
    tick();
    check("t1_nstart", q_start.size() - bst, 32'd1);
    check("t1_nsym", q_sym.size() - bs, 32'd7);
    check_hop("t1", bs, 1'b0, 7, 3);
    check("t1_valid_cycles", n_valid_cyc - vc, 32'd7);

    // N=14 hop occi=2: nSF 3 then 4
    bs = q_sym.size();
    bst = q_start.size();
    start_seq(4'd14, 1'b1, 3'd2);
    wait_done(200);
    check("t2_err", {30'd0, o_err}, 32'd0);
    tick();
    check("t2_nstart", q_start.size() - bst, 32'd2);
    check("t2_start0", {26'd0, q_start[bst]}, {26'd0, 3'd3, 3'd2});
    check("t2_start1", {26'd0, q_start[bst + 1]}, {26'd0, 3'd4, 3'd2});
    check("t2_nsym", q_sym.size() - bs, 32'd7);
    check_hop("t2h0", bs, 1'b0, 3, 2);
    check_hop("t2h1", bs + 3, 1'b1, 4, 2);

    // configuration errors
    cfg_err("cfg_n3", 4'd3, 1'b0, 3'd0);
    cfg_err("cfg_n15", 4'd15, 1'b0, 3'd0);
    cfg_err("cfg_n6_hop_occi1", 4'd6, 1'b1, 3'd1);

    // spreader rejects nSF
    sp_mode = 1;
    bs = q_sym.size();
    start_seq(4'd8, 1'b0, 3'd0);
    wait_done(100);
    check("unsup_err", {30'd0, o_err}, 32'd2);
    check("unsup_nsym", q_sym.size() - bs, 32'd0);
    tick();

    // spreader silent
    sp_mode = 2;
    nn = n_next;
    start_seq(4'd8, 1'b0, 3'd0);
    wait_done(100);
    check("to_err", {30'd0, o_err}, 32'd3);
    check("to_latency", t_done - t_next, TIMEOUT + 1);
    check("to_one_next", n_next - nn, 32'd1);
    tick();
    sp_mode = 0;

    // backpressure: ready low for 5 cycles on m=2
    bus.i_sym_ready = 1'b0;
    start_seq(4'd14, 1'b0, 3'd0);
    for (int s = 0; s < 7; s++) begin
      wait_sym(40);
      check($sformatf("bp_idx%0d", s), {29'd0, bus.o_sym_idx}, s);
      check($sformatf("bp_phi%0d", s), {27'd0, bus.o_sym_phi}, {27'd0, model_phi(7, 0, s)});
      if (s == 2) begin
        snap = outs_vec();
        nn = n_next;
        for (int k = 0; k < 5; k++) begin
          tick();
          check($sformatf("bp_stable%0d", k), outs_vec(), snap);
        end
        check("bp_no_next", n_next - nn, 32'd0);
      end
      bus.i_sym_ready = 1'b1;
      tick();
      bus.i_sym_ready = 1'b0;
    end
    wait_done(50);
    check("bp_err", {30'd0, o_err}, 32'd0);
    tick();

    // asynchronous reset in the middle of hop 1
    bus.i_sym_ready = 1'b1;
    start_seq(4'd14, 1'b1, 3'd0);
    repeat (20) tick();
    check("rst_busy_before", {31'd0, o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_outs", outs_vec(), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    nn = n_next;
    nd = n_done;
    repeat (10) tick();
    check("rst_idle", {31'd0, o_busy}, 32'd0);
    check("rst_no_next", n_next - nn, 32'd0);
    check("rst_no_done", n_done - nd, 32'd0);

    // abort while a symbol is presented, together with a transfer
    bus.i_sym_ready = 1'b0;
    start_seq(4'd14, 1'b0, 3'd1);
    wait_sym(40);
    i_abort = 1'b1;
    bus.i_sym_ready = 1'b1;
    tick();
    i_abort = 1'b0;
    bus.i_sym_ready = 1'b0;
    check("abort_idle", {31'd0, o_busy}, 32'd0);
    check("abort_sym_valid", {31'd0, bus.o_sym_valid}, 32'd0);
    check("abort_no_done_now", {31'd0, o_done}, 32'd0);
    nn = n_next;
    nd = n_done;
    repeat (20) tick();
    check("abort_no_done", n_done - nd, 32'd0);
    check("abort_no_next", n_next - nn, 32'd0);

    // recovery with the smallest hopping configuration: nSF 1 and 1
    bus.i_sym_ready = 1'b1;
    bs = q_sym.size();
    bst = q_start.size();
    start_seq(4'd4, 1'b1, 3'd0);
    wait_done(100);
    check("t4_err", {30'd0, o_err}, 32'd0);
    tick();
    check("t4_nstart", q_start.size() - bst, 32'd2);
    check("t4_nsym", q_sym.size() - bs, 32'd2);
    check_hop("t4h0", bs, 1'b0, 1, 0);
    check_hop("t4h1", bs + 1, 1'b1, 1, 0);

    check("pulse_overlap", n_overlap, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
